// File: rtl/triage_admit.sv
// Admission stage for the patient priority queue: allocates patient IDs, buffers
// arrivals in an ageing FIFO and offers {priority, ID} words to the queue.
module triage_admit #(
    parameter int DEPTH     = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arr_valid,
    input  logic [1:0] arr_prio,
    output logic       arr_ready,
    output logic       enq_valid,
    output logic [3:0] enq_data,
    input  logic       enq_ready,
    input  logic       rel_valid,
    input  logic [1:0] rel_id,
    output logic       rel_err,
    output logic [3:0] id_busy,
    output logic [2:0] pending,
    output logic       isfull,
    output logic       isempty
);

    localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);
    localparam logic [2:0] DEPTH_W = 3'(DEPTH);

    typedef struct packed {
        logic [1:0] prio;
        logic [1:0] id;
        logic [3:0] wait_cnt;
    } entry_t;

    entry_t     fifo_r   [DEPTH];
    entry_t     fifo_next_s [DEPTH];
    entry_t     aged_s   [DEPTH+1];
    logic [2:0] pending_r;
    logic [2:0] pending_next_s;
    logic [3:0] busy_r;
    logic [3:0] busy_next_s;
    logic       valid_r;
    logic       rel_err_r;
    logic       rel_err_next_s;
    logic       alive_r;
    logic       ready_s;
    logic       push_s;
    logic       pop_s;
    logic [1:0] new_id_s;
    logic [2:0] tail_s;
    logic [3:0] rel_mask_s;
    logic [3:0] alloc_mask_s;

    // One wait cycle for a resident entry; escalate priority when the limit is hit.
    function automatic entry_t age_entry(input entry_t e);
        entry_t r;
        r = e;
        if ((e.wait_cnt + 4'd1) == AGE_LIM) begin
            r.wait_cnt = 4'd0;
            if (e.prio != 2'd3) begin
                r.prio = e.prio + 2'd1;
            end else begin
                r.prio = e.prio;
            end
        end else begin
            r.wait_cnt = e.wait_cnt + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest_free(input logic [3:0] busy);
        logic [1:0] id;
        if (!busy[0]) begin
            id = 2'd0;
        end else if (!busy[1]) begin
            id = 2'd1;
        end else if (!busy[2]) begin
            id = 2'd2;
        end else begin
            id = 2'd3;
        end
        return id;
    endfunction

    // Handshakes, ID bookkeeping and release checking.
    always_comb begin
        ready_s        = alive_r && (busy_r != 4'hF) && (pending_r < DEPTH_W);
        push_s         = arr_valid && ready_s;
        pop_s          = valid_r && enq_ready;
        new_id_s       = lowest_free(busy_r);
        alloc_mask_s   = 4'h0;
        rel_mask_s     = 4'h0;
        rel_err_next_s = 1'b0;
        if (push_s) begin
            alloc_mask_s = 4'h1 << new_id_s;
        end else begin
            alloc_mask_s = 4'h0;
        end
        // A released ID is still busy in the pre-edge map, so it cannot be reallocated this edge.
        if (rel_valid && busy_r[rel_id]) begin
            rel_mask_s = 4'h1 << rel_id;
        end else if (rel_valid) begin
            rel_err_next_s = 1'b1;
        end else begin
            rel_mask_s = 4'h0;
        end
        busy_next_s    = (busy_r & ~rel_mask_s) | alloc_mask_s;
        pending_next_s = pending_r + {2'b00, push_s} - {2'b00, pop_s};
        tail_s         = pending_r - {2'b00, pop_s};
    end

    // FIFO next state: age residents, shift on pop, write the tail on push.
    always_comb begin
        aged_s[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) < pending_r) begin
                aged_s[i] = age_entry(fifo_r[i]);
            end else begin
                aged_s[i] = '0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (pop_s) begin
                fifo_next_s[i] = aged_s[i+1];
            end else begin
                fifo_next_s[i] = aged_s[i];
            end
            if (push_s && (3'(i) == tail_s)) begin
                fifo_next_s[i] = '{prio: arr_prio, id: new_id_s, wait_cnt: 4'd0};
            end else begin
                fifo_next_s[i] = fifo_next_s[i];
            end
        end
    end

    // State registers; reset clears every entry, counter and ID immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
            pending_r <= 3'd0;
            busy_r    <= 4'h0;
            valid_r   <= 1'b0;
            rel_err_r <= 1'b0;
            alive_r   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= fifo_next_s[i];
            end
            pending_r <= pending_next_s;
            busy_r    <= busy_next_s;
            valid_r   <= (pending_next_s != 3'd0);
            rel_err_r <= rel_err_next_s;
            alive_r   <= 1'b1;
        end
    end

    assign arr_ready = ready_s;
    assign enq_valid = valid_r;
    assign enq_data  = {fifo_r[0].prio, fifo_r[0].id};
    assign rel_err   = rel_err_r;
    assign id_busy   = busy_r;
    assign pending   = pending_r;
    assign isfull    = (busy_r == 4'hF);
    assign isempty   = (busy_r == 4'h0);

endmodule

// File: tb/tb_triage_admit.sv
// Directed bench for triage_admit: a vector table for the main flow plus
// hand-written ageing and asynchronous-reset sequences.
module tb_triage_admit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arr_valid;
    logic [1:0] arr_prio;
    logic       arr_ready;
    logic       enq_valid;
    logic [3:0] enq_data;
    logic       enq_ready;
    logic       rel_valid;
    logic [1:0] rel_id;
    logic       rel_err;
    logic [3:0] id_busy;
    logic [2:0] pending;
    logic       isfull;
    logic       isempty;

    int checks = 0;
    int errors = 0;

    triage_admit #(.DEPTH(4), .AGE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .arr_valid(arr_valid), .arr_prio(arr_prio), .arr_ready(arr_ready),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .rel_valid(rel_valid), .rel_id(rel_id), .rel_err(rel_err),
        .id_busy(id_busy), .pending(pending), .isfull(isfull), .isempty(isempty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [1:0] ap;
        logic       er;
        logic       rv;
        logic [1:0] rid;
        logic       x_ready;
        logic       x_valid;
        logic [3:0] x_data;
        logic [3:0] x_busy;
        logic [2:0] x_pend;
        logic       x_err;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " enq_valid"}, 8'(enq_valid), 8'd0);
        check({tag, " enq_data"},  8'(enq_data),  8'd0);
        check({tag, " id_busy"},   8'(id_busy),   8'd0);
        check({tag, " pending"},   8'(pending),   8'd0);
        check({tag, " rel_err"},   8'(rel_err),   8'd0);
        check({tag, " isfull"},    8'(isfull),    8'd0);
        check({tag, " isempty"},   8'(isempty),   8'd1);
        check({tag, " arr_ready"}, 8'(arr_ready), 8'd0);
    endtask

    task automatic idle_inputs();
        arr_valid = 1'b0; arr_prio = 2'd0; enq_ready = 1'b0;
        rel_valid = 1'b0; rel_id = 2'd0;
    endtask

    // Leaves the bench at a falling edge one full cycle after reset release.
    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " ready after release"}, 8'(arr_ready), 8'd1);
    endtask

    initial begin
        // av ap er rv rid | ready valid data busy pend err
        vt[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1000, 4'b0001, 3'd1, 1'b0};
        vt[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1000, 4'b0011, 3'd2, 1'b0};
        vt[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1000, 4'b0111, 3'd3, 1'b0};
        vt[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b1111, 3'd4, 1'b0};
        vt[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1000, 4'b1111, 3'd4, 1'b0};
        vt[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0101, 4'b1111, 3'd3, 1'b0};
        vt[6]  = '{1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0101, 4'b1101, 3'd3, 1'b0};
        vt[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0101, 4'b1111, 3'd4, 1'b0};
        vt[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1110, 4'b1111, 3'd3, 1'b0};
        vt[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0011, 4'b1111, 3'd2, 1'b0};
        vt[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0101, 4'b1111, 3'd1, 1'b0};
        vt[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b1111, 3'd0, 1'b0};
        vt[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 4'b1110, 3'd0, 1'b0};
        vt[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b1010, 3'd0, 1'b0};
        vt[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 4'b1010, 3'd0, 1'b1};
        vt[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 4'b1010, 3'd0, 1'b0};
        vt[16] = '{1'b1, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 4'b0000, 4'b0011, 3'd1, 1'b0};
        vt[17] = '{1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1110, 4'b0111, 3'd1, 1'b0};
        vt[18] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd0, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        do_reset("reset0");

        // Table: drive on the falling edge, check on the next falling edge.
        for (int i = 0; i < 19; i++) begin
            arr_valid = vt[i].av;
            arr_prio  = vt[i].ap;
            enq_ready = vt[i].er;
            rel_valid = vt[i].rv;
            rel_id    = vt[i].rid;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d arr_ready", i), 8'(arr_ready), 8'(vt[i].x_ready));
            check($sformatf("row%0d enq_valid", i), 8'(enq_valid), 8'(vt[i].x_valid));
            check($sformatf("row%0d enq_data", i),  8'(enq_data),  8'(vt[i].x_data));
            check($sformatf("row%0d id_busy", i),   8'(id_busy),   8'(vt[i].x_busy));
            check($sformatf("row%0d pending", i),   8'(pending),   8'(vt[i].x_pend));
            check($sformatf("row%0d rel_err", i),   8'(rel_err),   8'(vt[i].x_err));
            check($sformatf("row%0d isfull", i),    8'(isfull),    8'(vt[i].x_busy == 4'hF));
            check($sformatf("row%0d isempty", i),   8'(isempty),   8'(vt[i].x_busy == 4'h0));
        end

        // Ageing: a prio-1 entry held at the head escalates every 8 cycles and saturates.
        do_reset("reset1");
        arr_valid = 1'b1; arr_prio = 2'd1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        for (int c = 1; c <= 26; c++) begin
            logic [1:0] exp_p;
            if (c <= 8) begin
                exp_p = 2'd1;
            end else if (c <= 16) begin
                exp_p = 2'd2;
            end else begin
                exp_p = 2'd3;
            end
            check($sformatf("age cycle%0d prio", c), 8'(enq_data[3:2]), 8'(exp_p));
            check($sformatf("age cycle%0d id", c),   8'(enq_data[1:0]), 8'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset with three entries pending.
        do_reset("reset2");
        arr_valid = 1'b1; arr_prio = 2'd3;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        idle_inputs();
        check("pre-reset pending", 8'(pending), 8'd3);
        check("pre-reset busy",    8'(id_busy), 8'h7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midcycle");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post-reset arr_ready", 8'(arr_ready), 8'd1);
        check("post-reset pending",   8'(pending),   8'd0);
        arr_valid = 1'b1; arr_prio = 2'd2;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check("post-reset first id", 8'(enq_data), 8'b1000);
        check("post-reset busy",     8'(id_busy),  8'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
